// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the rv32i core.
// Sequencer state encoding, next-PC select codes and default vectors.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INCR  = 2'd1,
    PC_REDIR = 2'd2,
    PC_TRAP  = 2'd3
  } pc_sel_t;

  // Result of the next-PC selection, consumed by the sequencer registers
  typedef struct packed {
    logic [31:0] pc;
    pc_sel_t     sel;
    logic        misaligned;
  } pc_mux_t;

  localparam logic [31:0] INST_BYTES         = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR   = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR    = 32'h0000_0100;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: redirect / trap / increment / hold, with target alignment check.
// Purely combinational; hold is chosen whenever neither redirect nor advance is asserted.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  input  logic        advance,
  output pc_mux_t     mux
);

  logic target_ok;

  assign target_ok = is_aligned(redirect_target);

  // Redirect outranks advance so a stalled pipe never drops a taken branch
  always_comb begin
    mux            = '0;
    mux.pc         = pc;
    mux.sel        = PC_HOLD;
    mux.misaligned = 1'b0;
    if (redirect_en) begin
      if (target_ok) begin
        mux.pc  = redirect_target;
        mux.sel = PC_REDIR;
      end else begin
        mux.pc         = TRAP_VECTOR;
        mux.sel        = PC_TRAP;
        mux.misaligned = 1'b1;
      end
    end else if (advance) begin
      mux.pc  = pc + INST_BYTES;
      mux.sel = PC_INCR;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: boot hold-off, redirects, halt/resume and misalign traps.
// Latency 1 cycle redirect-to-PC; stall or non-RUN state holds the PC and asserts fetch_stall.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        boot_done,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic        fetch_stall,
  output logic        flush,
  output logic        misalign_trap,
  output logic [31:0] trap_addr,
  output logic [1:0]  seq_state,
  output logic [31:0] fetch_count
);

  seq_state_t  state_q;
  logic [31:0] pc_q;
  logic        redirect_en;
  logic        advance;
  pc_mux_t     mux;

  // HALT still accepts redirects so in-flight branches drain into the PC
  assign redirect_en = redirect_valid && (state_q == RUN || state_q == HALT);
  assign advance     = (state_q == RUN) && !stall;

  pc_next_mux #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_next_mux (
    .pc              (pc_q),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .advance         (advance),
    .mux             (mux)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      flush         <= 1'b0;
      misalign_trap <= 1'b0;
      trap_addr     <= 32'h0;
      fetch_count   <= 32'h0;
    end else begin
      pc_q          <= mux.pc;
      flush         <= redirect_en;
      misalign_trap <= mux.misaligned;
      if (mux.misaligned) begin
        trap_addr <= redirect_target;
      end
      if (mux.sel == PC_INCR) begin
        fetch_count <= fetch_count + 32'd1;
      end
      case (state_q)
        BOOT: if (boot_done) state_q <= RUN;
        RUN:  if (halt_req) state_q <= HALT;
        HALT: if (resume && !halt_req) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

  assign pc_next     = pc_q;
  assign seq_state   = state_q;
  assign fetch_stall = (state_q != RUN) || stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstn;
  logic        boot_done;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_next;
  logic        fetch_stall;
  logic        flush;
  logic        misalign_trap;
  logic [31:0] trap_addr;
  logic [1:0]  seq_state;
  logic [31:0] fetch_count;

  int checks = 0;
  int passed = 0;

  fetch_sequencer dut (
    .clk             (clk),
    .rstn            (rstn),
    .boot_done       (boot_done),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_next         (pc_next),
    .fetch_stall     (fetch_stall),
    .flush           (flush),
    .misalign_trap   (misalign_trap),
    .trap_addr       (trap_addr),
    .seq_state       (seq_state),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; boot_done = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; halt_req = 1'b0; resume = 1'b0;
    step(); step();
    check("rst_pc", pc_next, 32'h0);
    check("rst_state", {30'h0, seq_state}, 32'd0);
    check("rst_fstall", {31'h0, fetch_stall}, 32'd1);
    check("rst_flush", {31'h0, flush}, 32'd0);
    check("rst_trap", {31'h0, misalign_trap}, 32'd0);
    check("rst_trap_addr", trap_addr, 32'h0);
    check("rst_count", fetch_count, 32'h0);

    // Boot: redirects and halts must be ignored
    rstn = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40; halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("boot_pc", pc_next, 32'h0);
      check("boot_fstall", {31'h0, fetch_stall}, 32'd1);
      check("boot_flush", {31'h0, flush}, 32'd0);
      check("boot_state", {30'h0, seq_state}, 32'd0);
    end
    redirect_valid = 1'b0; halt_req = 1'b0; boot_done = 1'b1;
    step();
    check("boot_run_state", {30'h0, seq_state}, 32'd1);
    check("boot_run_pc", pc_next, 32'h0);
    check("run_fstall", {31'h0, fetch_stall}, 32'd0);
    boot_done = 1'b0;
    step(); check("pc_4", pc_next, 32'h4);
    step(); check("pc_8", pc_next, 32'h8);
    step(); check("pc_12", pc_next, 32'hC);
    check("count_3", fetch_count, 32'd3);
    step(); check("pc_16", pc_next, 32'h10);

    // Stall holds PC and count
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc_next, 32'h10);
      check("stall_count", fetch_count, 32'd4);
      check("stall_fstall", {31'h0, fetch_stall}, 32'd1);
    end
    stall = 1'b0;
    step();
    check("unstall_pc", pc_next, 32'h14);
    check("unstall_count", fetch_count, 32'd5);
    for (int i = 0; i < 11; i++) step();
    check("pc_40", pc_next, 32'h40);
    check("count_16", fetch_count, 32'd16);

    // Redirect wins over stall
    redirect_valid = 1'b1; redirect_target = 32'h200; stall = 1'b1;
    step();
    check("redir_pc", pc_next, 32'h200);
    check("redir_flush", {31'h0, flush}, 32'd1);
    check("redir_notrap", {31'h0, misalign_trap}, 32'd0);
    check("redir_count", fetch_count, 32'd16);
    redirect_valid = 1'b0;
    step();
    check("redir_flush_off", {31'h0, flush}, 32'd0);
    check("redir_hold", pc_next, 32'h200);

    // Misaligned target, then back-to-back aligned redirect
    stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h202;
    step();
    check("mis_pc", pc_next, 32'h100);
    check("mis_trap_addr", trap_addr, 32'h202);
    check("mis_trap", {31'h0, misalign_trap}, 32'd1);
    check("mis_flush", {31'h0, flush}, 32'd1);
    check("mis_count", fetch_count, 32'd16);
    redirect_target = 32'h300;
    step();
    check("b2b_pc", pc_next, 32'h300);
    check("b2b_flush", {31'h0, flush}, 32'd1);
    check("b2b_trap_off", {31'h0, misalign_trap}, 32'd0);
    check("b2b_trap_addr", trap_addr, 32'h202);
    redirect_valid = 1'b0;
    step();
    check("after_b2b_pc", pc_next, 32'h304);
    check("after_b2b_flush", {31'h0, flush}, 32'd0);
    check("after_b2b_count", fetch_count, 32'd17);

    // Halt with simultaneous redirect
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    step();
    check("halt_state", {30'h0, seq_state}, 32'd2);
    check("halt_pc", pc_next, 32'h80);
    check("halt_fstall", {31'h0, fetch_stall}, 32'd1);
    check("halt_flush", {31'h0, flush}, 32'd1);
    redirect_valid = 1'b0;
    step();
    check("halt_hold_pc", pc_next, 32'h80);
    check("halt_flush_off", {31'h0, flush}, 32'd0);
    check("halt_count", fetch_count, 32'd17);
    resume = 1'b1;
    step();
    check("resume_blocked", {30'h0, seq_state}, 32'd2);
    halt_req = 1'b0;
    step();
    check("resume_run", {30'h0, seq_state}, 32'd1);
    check("resume_pc", pc_next, 32'h80);
    resume = 1'b0;
    step();
    check("resume_next_pc", pc_next, 32'h84);
    check("resume_count", fetch_count, 32'd18);

    // Wrap at top of address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    check("wrap_top", pc_next, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    check("wrap_zero", pc_next, 32'h0);
    check("wrap_count", fetch_count, 32'd19);

    // Halt, misaligned redirect while halted, then reset mid-HALT
    halt_req = 1'b1;
    step();
    check("halt2_state", {30'h0, seq_state}, 32'd2);
    check("halt2_pc", pc_next, 32'h4);
    check("halt2_count", fetch_count, 32'd20);
    redirect_valid = 1'b1; redirect_target = 32'h123;
    step();
    check("halt_mis_pc", pc_next, 32'h100);
    check("halt_mis_addr", trap_addr, 32'h123);
    check("halt_mis_trap", {31'h0, misalign_trap}, 32'd1);
    check("halt_mis_state", {30'h0, seq_state}, 32'd2);
    redirect_valid = 1'b0; rstn = 1'b0;
    step();
    check("rst2_pc", pc_next, 32'h0);
    check("rst2_state", {30'h0, seq_state}, 32'd0);
    check("rst2_flush", {31'h0, flush}, 32'd0);
    check("rst2_trap", {31'h0, misalign_trap}, 32'd0);
    check("rst2_trap_addr", trap_addr, 32'h0);
    check("rst2_count", fetch_count, 32'h0);
    check("rst2_fstall", {31'h0, fetch_stall}, 32'd1);

    rstn = 1'b1; halt_req = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
